regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (wen/waddr/wdata) between NUM_SRC writeback requesters (ALU, LSU, CSR).
- Arbitration is round-robin with a valid/ready handshake per source.
- The winning request is registered into a one-entry output stage that drives the register file.
- The block also exposes a pending-write indicator for hazard logic and a saturating contention counter for debug.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_rr.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants for the register-file writeback path.
//   - ADDR_WIDTH / WORD_LEN : default register-file geometry
//   - NUM_WB_SRC            : number of writeback requesters
//   - wb_src_e              : requester index (ALU, LSU, CSR)
//   - ptr_width()           : width of an index into N requesters
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int WORD_LEN   = 32;
  localparam int NUM_WB_SRC = 3;

  typedef enum int {
    SRC_ALU = 0,
    SRC_LSU = 1,
    SRC_CSR = 2
  } wb_src_e;

  // At least one bit so a single-requester build still has a legal pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. Scans req starting at ptr,
//   wrapping modulo N, and grants the first requester found.
//   Ports:
//     req    [N-1:0]  request vector
//     ptr    [PW-1:0] index where the scan starts (must be < N)
//     enable          when low, grant is forced to zero
//     grant  [N-1:0]  one-hot-or-zero grant
// -----------------------------------------------------------------------------
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter  int N  = NUM_WB_SRC,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant
);

  logic [PW:0] idx;
  logic        found;

  always_comb begin
    // NOTE: every variable driven here gets a default before the loop so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k with a manual wrap; avoids a general modulo operator.
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = enable;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port between NUM_SRC writeback
//   requesters using round-robin arbitration and a valid/ready handshake.
//   The winner is registered into a one-entry output stage (1-cycle latency,
//   one write per cycle). Writes to register 0 are consumed but never issued.
//   Ports:
//     clk, reset            clock; synchronous active-low reset
//     req_valid/addr/data   per-source request, source i at slice i
//     req_ready             one-hot-or-zero accept
//     stall                 blocks all new grants
//     rf_wen/waddr/wdata    register-file write port
//     pending               one-hot of rf_waddr while rf_wen is high
//     contention_cnt        saturating count of contended, unstalled cycles
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int NUM_SRC    = NUM_WB_SRC,
  parameter  int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
  parameter  int WORD_LEN   = regfile_pkg::WORD_LEN,
  parameter  int CNT_WIDTH  = 16,
  localparam int PW         = ptr_width(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_SRC-1:0]             req_valid,
  input  logic [NUM_SRC*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_SRC*WORD_LEN-1:0]    req_data,
  output logic [NUM_SRC-1:0]             req_ready,
  input  logic                           stall,
  output logic                           rf_wen,
  output logic [ADDR_WIDTH-1:0]          rf_waddr,
  output logic [WORD_LEN-1:0]            rf_wdata,
  output logic [2**ADDR_WIDTH-1:0]       pending,
  output logic [CNT_WIDTH-1:0]           contention_cnt
);

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         next_ptr;
  logic [NUM_SRC-1:0]    grant;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WORD_LEN-1:0]   sel_data;
  logic                  multi_valid;

  // Grant depends only on valids, the pointer, stall and reset.
  rr_arbiter #(.N(NUM_SRC)) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (ptr),
    .enable (~stall & reset),
    .grant  (grant)
  );

  assign req_ready = grant;
  // A grant is only ever given to a valid source, so any grant is a handshake.
  assign accept    = |grant;

  // Two or more bits set: clearing the lowest set bit leaves something.
  assign multi_valid = |(req_valid & (req_valid - NUM_SRC'(1)));

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    next_ptr = ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*WORD_LEN +: WORD_LEN];
        next_ptr = (i == NUM_SRC - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      // NOTE: the data/address flops are reset too, so the write port shows
      // defined values straight out of reset; any handshake on this edge and
      // any write held in the stage are dropped.
      ptr            <= '0;
      rf_wen         <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      contention_cnt <= '0;
    end else begin
      if (accept) begin
        ptr      <= next_ptr;
        rf_wen   <= (sel_addr != '0);   // x0 writes are consumed silently
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end else begin
        rf_wen   <= 1'b0;
      end
      if (multi_valid && !stall && !(&contention_cnt))
        contention_cnt <= contention_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    pending = '0;
    if (rf_wen) pending[rf_waddr] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;
  logic [3:0]  contention_cnt;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.CNT_WIDTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .stall          (stall),
    .rf_wen         (rf_wen),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .pending        (pending),
    .contention_cnt (contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file as seen by whatever sits on the write port.
  logic [31:0] tb_rf [32];
  always @(posedge clk) if (rf_wen === 1'b1) tb_rf[rf_waddr] <= rf_wdata;

  // ---------------- reference model (behavioural) ----------------
  int          m_ptr = 0;
  logic        m_wen = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_data = '0;
  int          m_cnt = 0;
  logic [31:0] m_rf [32];

  // Which source wins this cycle, or -1.
  function automatic int model_grant();
    if (reset !== 1'b1 || stall !== 1'b0) return -1;
    for (int k = 0; k < 3; k++) begin
      int s;
      s = (m_ptr + k) % 3;
      if (req_valid[s]) return s;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rst_v, input logic st, input logic [2:0] v,
                       input logic [14:0] a, input logic [95:0] d);
    reset     = rst_v;
    stall     = st;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic check_model(input string tag);
    int         g;
    logic [2:0] er;
    g  = model_grant();
    er = (g >= 0) ? 3'(1 << g) : 3'b000;
    check({tag, "_ready"}, 64'(req_ready), 64'(er));
    check({tag, "_wen"}, 64'(rf_wen), 64'(m_wen));
    if (m_wen) begin
      check({tag, "_waddr"}, 64'(rf_waddr), 64'(m_addr));
      check({tag, "_wdata"}, 64'(rf_wdata), 64'(m_data));
    end
    check({tag, "_pending"}, 64'(pending), m_wen ? (64'(1) << m_addr) : 64'(0));
    check({tag, "_cnt"}, 64'(contention_cnt), 64'(m_cnt));
  endtask

  // Advance one clock and move the model across the same edge.
  task automatic step();
    int g;
    g = model_grant();
    @(posedge clk);
    if (m_wen) m_rf[m_addr] = m_data;
    if (reset !== 1'b1) begin
      m_ptr = 0; m_wen = 1'b0; m_addr = 0; m_data = '0; m_cnt = 0;
    end else begin
      if (g >= 0) begin
        m_addr = int'(req_addr[g*5 +: 5]);
        m_data = req_data[g*32 +: 32];
        m_wen  = (m_addr != 0);
        m_ptr  = (g + 1) % 3;
      end else begin
        m_wen = 1'b0;
      end
      if ($countones(req_valid) >= 2 && !stall && m_cnt < 15) m_cnt++;
    end
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst_n;
    logic        stall;
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  exp_ready;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_cnt;
  } vec_t;

  function automatic logic [14:0] pa(input int a0, input int a1, input int a2);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [95:0] pd(input logic [31:0] d0, input logic [31:0] d1,
                                     input logic [31:0] d2);
    return {d2, d1, d0};
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic [2:0] v,
                              input logic [14:0] a, input logic [95:0] d,
                              input logic [2:0] er, input logic ew, input int ea,
                              input logic [31:0] ed, input int ec);
    vec_t t;
    t.rst_n = r;  t.stall = s;  t.valid = v;  t.addr = a;  t.data = d;
    t.exp_ready = er;  t.exp_wen = ew;  t.exp_waddr = 5'(ea);
    t.exp_wdata = ed;  t.exp_cnt = 4'(ec);
    return t;
  endfunction

  vec_t vecs [24];

  initial begin
    logic [2:0]  rr_ready [6];
    logic [4:0]  rr_addr  [6];
    logic [31:0] rr_data  [6];

    for (int i = 0; i < 32; i++) begin
      tb_rf[i] = '0;
      m_rf[i]  = '0;
    end

    // Reset held with everything valid.
    for (int i = 0; i < 3; i++)
      vecs[i] = mk(0, 0, 3'b111, pa(1, 2, 3), pd(1, 2, 3), 3'b000, 0, 0, 0, 0);
    // Single source 1.
    vecs[3] = mk(1, 0, 3'b010, pa(0, 5, 0), pd(0, 32'hDEADBEEF, 0), 3'b010, 0, 0, 0, 0);
    vecs[4] = mk(1, 0, 3'b000, '0, '0, 3'b000, 1, 5, 32'hDEADBEEF, 0);
    vecs[5] = mk(1, 0, 3'b000, '0, '0, 3'b000, 0, 0, 0, 0);
    vecs[6] = mk(0, 0, 3'b000, '0, '0, 3'b000, 0, 0, 0, 0);
    // Round robin from ptr=0 with all three valid.
    rr_ready = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rr_addr  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd1, 5'd2};
    rr_data  = '{32'h0, 32'h100, 32'h101, 32'h102, 32'h100, 32'h101};
    for (int i = 0; i < 6; i++)
      vecs[7+i] = mk(1, 0, 3'b111, pa(1, 2, 3), pd(32'h100, 32'h101, 32'h102),
                     rr_ready[i], (i != 0), int'(rr_addr[i]), rr_data[i], i);
    vecs[13] = mk(1, 0, 3'b000, '0, '0, 3'b000, 1, 3, 32'h102, 6);
    // x0 discard, then source 1 next.
    vecs[14] = mk(1, 0, 3'b011, pa(0, 9, 0), pd(32'h1234, 32'h55, 0), 3'b001, 0, 0, 0, 6);
    vecs[15] = mk(1, 0, 3'b010, pa(0, 9, 0), pd(32'h1234, 32'h55, 0), 3'b010, 0, 0, 0, 7);
    // Stall: in-flight write completes, ptr and counter frozen.
    vecs[16] = mk(1, 1, 3'b011, pa(4, 9, 0), pd(32'h44, 32'h66, 0), 3'b000, 1, 9, 32'h55, 7);
    vecs[17] = mk(1, 1, 3'b011, pa(4, 9, 0), pd(32'h44, 32'h66, 0), 3'b000, 0, 0, 0, 7);
    vecs[18] = mk(1, 0, 3'b011, pa(4, 9, 0), pd(32'h44, 32'h66, 0), 3'b001, 0, 0, 0, 7);
    vecs[19] = mk(1, 0, 3'b000, '0, '0, 3'b000, 1, 4, 32'h44, 8);
    // Source 2 presenting while reset is low; ptr returns to 0.
    vecs[20] = mk(0, 0, 3'b100, pa(0, 0, 7), pd(0, 0, 32'h77), 3'b000, 0, 0, 0, 8);
    vecs[21] = mk(1, 0, 3'b111, pa(1, 2, 7), pd(32'h11, 32'h22, 32'h77), 3'b001, 0, 0, 0, 0);
    // Reset while the output stage holds a write.
    vecs[22] = mk(0, 0, 3'b000, '0, '0, 3'b000, 1, 1, 32'h11, 1);
    vecs[23] = mk(1, 0, 3'b000, '0, '0, 3'b000, 0, 0, 0, 0);

    // Initial reset edge so the DUT leaves X.
    apply(0, 0, 3'b000, '0, '0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      string t;
      t = $sformatf("row%0d", i);
      apply(vecs[i].rst_n, vecs[i].stall, vecs[i].valid, vecs[i].addr, vecs[i].data);
      #1;
      check({t, "_tbl_ready"}, 64'(req_ready), 64'(vecs[i].exp_ready));
      check({t, "_tbl_wen"}, 64'(rf_wen), 64'(vecs[i].exp_wen));
      if (vecs[i].exp_wen) begin
        check({t, "_tbl_waddr"}, 64'(rf_waddr), 64'(vecs[i].exp_waddr));
        check({t, "_tbl_wdata"}, 64'(rf_wdata), 64'(vecs[i].exp_wdata));
      end
      check({t, "_tbl_pending"}, 64'(pending),
            vecs[i].exp_wen ? (64'(1) << vecs[i].exp_waddr) : 64'(0));
      check({t, "_tbl_cnt"}, 64'(contention_cnt), 64'(vecs[i].exp_cnt));
      check_model(t);
      step();
    end

    // Contention saturation: 20 contended cycles into a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      apply(1, 0, 3'b111, pa(10, 11, 12), pd(i, i + 100, i + 200));
      #1;
      check_model($sformatf("sat%0d", i));
      step();
    end
    apply(1, 0, 3'b000, '0, '0);
    #1;
    check("cnt_saturated", 64'(contention_cnt), 64'hF);
    check_model("sat_end");
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [14:0] a;
      logic [95:0] d;
      for (int s = 0; s < 3; s++) begin
        a[s*5 +: 5]  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
        d[s*32 +: 32] = $urandom;
      end
      apply(($urandom_range(0, 39) != 0), ($urandom_range(0, 6) == 0),
            3'($urandom), a, d);
      #1;
      check_model($sformatf("rnd%0d", i));
      step();
    end

    // Drain the stage, then compare register-file contents (ordering of
    // same-destination writes shows up here).
    apply(1, 0, 3'b000, '0, '0);
    #1;
    step();
    step();
    for (int r = 0; r < 32; r++)
      check($sformatf("rf_x%0d", r), 64'(tb_rf[r]), 64'(m_rf[r]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
